vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between VGA scan-out and a pixel writer (CPU or drawing engine). It takes the column/row counters and sync pulses from the 800x525 sync generator and owns the RAM port. During the active region it issues display reads; during blanking it grants writes over a valid/ready handshake. Sync outputs are delayed to stay aligned with the returned pixel data.

Parameters:
H_ACTIVE, 640, active columns per line
V_ACTIVE, 480, active rows per frame
DATA_W, 3, pixel width (1 bit each R,G,B)
ADDR_W, 19, RAM address width (must hold H_ACTIVE*V_ACTIVE-1)

Ports:
CLK  in  1  pixel clock, 25 MHz
RST_N  in  1  asynchronous active-low reset
CountCol  in  10  column counter from sync generator
CountRow  in  10  row counter from sync generator
H_Sync_In  in  1  H sync from sync generator
V_Sync_In  in  1  V sync from sync generator
Wr_Valid  in  1  writer has a pixel to store
Wr_Addr  in  ADDR_W  linear pixel address (row*H_ACTIVE+col)
Wr_Data  in  DATA_W  pixel value
Wr_Ready  out  1  write accepted this cycle when Wr_Valid=1
Wr_Err  out  1  one-cycle pulse: accepted write was out of range and dropped
Mem_Addr  out  ADDR_W  registered RAM address
Mem_We  out  1  registered RAM write enable
Mem_WData  out  DATA_W  registered RAM write data
Mem_RData  in  DATA_W  RAM read data, valid the cycle after Mem_Addr
Pix_Data  out  DATA_W  pixel to DAC, forced 0 outside the active region
H_Sync_Out  out  1  H_Sync_In delayed 3 cycles
V_Sync_Out  out  1  V_Sync_In delayed 3 cycles
Frame_Start  out  1  one-cycle pulse when CountCol=0 and CountRow=0 is sampled

Behaviour:
- Reset (RST_N=0, async): Mem_Addr=0, Mem_We=0, Mem_WData=0, Pix_Data=0, Wr_Err=0, Frame_Start=0, H_Sync_Out=1, V_Sync_Out=1, delay lines filled with 1 (syncs) and 0 (active flags). Wr_Ready=0 while RST_N=0.
- Active = (CountCol<H_ACTIVE)&&(CountRow<V_ACTIVE), evaluated on the counters in the current cycle.
- FSM, 2 states, next state taken from Active: S_DISP (Active=1) and S_BLANK (Active=0). The state reflects the previous cycle's ownership and is used only for the owner tag in the pipeline.
- Wr_Ready is combinational: 1 when Active=0 and RST_N=1, otherwise 0. It must not depend on Wr_Valid.
- Display read, cycle t with Active=1: at edge t+1, Mem_Addr=CountRow*H_ACTIVE+CountCol and Mem_We=0. An incremental counter is allowed; it clears on Frame_Start and holds during blanking. Mem_RData is valid during t+2 and registers into Pix_Data at edge t+3. Total latency is 3 cycles, matching the sync delay.
- Pix_Data=0 whenever the 3-cycle-delayed Active flag is 0.
- Write, cycle t with Wr_Valid=1 and Wr_Ready=1 (handshake):
  - If Wr_Addr<H_ACTIVE*V_ACTIVE: at edge t+1, Mem_Addr=Wr_Addr, Mem_WData=Wr_Data, Mem_We=1.
  - Otherwise: Mem_We=0 and Wr_Err=1 for one cycle.
  - One write per cycle, so back-to-back writes run at 1/cycle through the whole blanking interval.
- No handshake and Active=0: Mem_We=0; Mem_Addr and Mem_WData hold.
- Active has absolute priority. On the cycle the counters re-enter the active region, Wr_Ready drops combinationally and a pending Wr_Valid waits; the writer must hold Wr_Addr and Wr_Data stable.
- Counter wrap (CountCol 799->0, CountRow 524->0) needs no special handling beyond the Active decode. Frame_Start pulses on the sampled (0,0).
- Reset mid-line: the pipeline clears and the first post-reset outputs follow the counters normally. Mem_We is never asserted during reset.

Test Plan:
- Reset held with Wr_Valid=1, then release at CountCol=0, CountRow=0 -> during reset Mem_We=0, Wr_Ready=0 and Pix_Data=0; after release Frame_Start pulses once and Mem_Addr=0 at the first edge.
- Active read, counters at (5,2) in cycle t, Mem_RData model returning address-low-bits -> Mem_Addr=1285 at t+1, Pix_Data=1285&7=5 at t+3, H_Sync_Out equals H_Sync_In of cycle t.
- Writer holds Wr_Valid=1, Wr_Addr=100, Wr_Data=3 across cols 635..645 of row 0 -> Wr_Ready=0 for cols 635..639; accept at col 640; Mem_We=1, Mem_Addr=100, Mem_WData=3 at the next edge; no Mem_We during active cycles.
- Burst of 160 writes during horizontal blanking (cols 640..799) -> 160 consecutive Mem_We cycles; Wr_Ready drops exactly when CountCol wraps to 0 on an active row.
- Out-of-range write Wr_Addr=307200 during vertical blanking (row 500) -> Wr_Err pulses 1 cycle, Mem_We=0, the next valid write is accepted normally.
- Full frame with an all-0x7 RAM -> Pix_Data=7 on exactly 640*480 cycles per frame, 0 on all blanking cycles, aligned to the 3-cycle-delayed syncs.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display reads own the RAM in the active region and
// the pixel writer gets it during blanking. Syncs are delayed to match read latency.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 3,
  parameter int ADDR_W   = 19
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [9:0]        CountCol,
  input  logic [9:0]        CountRow,
  input  logic              H_Sync_In,
  input  logic              V_Sync_In,
  input  logic              Wr_Valid,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Wr_Ready,
  output logic              Wr_Err,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_We,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic [DATA_W-1:0] Pix_Data,
  output logic              H_Sync_Out,
  output logic              V_Sync_Out,
  output logic              Frame_Start,
  output logic              Dbg_State
);

  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_DISP  = 1'b1;

  localparam logic [9:0]        H_LIM   = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM   = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(H_ACTIVE * V_ACTIVE);

  logic              active;
  logic              wr_fire;
  logic              wr_in_range;
  logic [ADDR_W-1:0] disp_addr;
  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic              own_d1;
  logic [2:0]        hs_d;
  logic [2:0]        vs_d;

  assign active = (CountCol < H_LIM) && (CountRow < V_LIM);

  // Handshake: a write transfers in any cycle where Wr_Valid && Wr_Ready. Wr_Ready
  // depends only on the counters and reset, so a writer caught by the active region
  // simply keeps Wr_Valid/Wr_Addr/Wr_Data stable until blanking comes back.
  assign Wr_Ready    = RST_N && !active;
  assign wr_fire     = Wr_Valid && Wr_Ready;
  assign wr_in_range = Wr_Addr < FB_SIZE;

  assign disp_addr = ADDR_W'(CountRow) * ADDR_W'(H_ACTIVE) + ADDR_W'(CountCol);
  assign state_nxt = active ? S_DISP : S_BLANK;
  assign Dbg_State = state[0];

  assign H_Sync_Out = hs_d[2];
  assign V_Sync_Out = vs_d[2];

  // Ownership tag pipeline: state (t+1) -> own_d1 (t+2) -> gates Pix_Data at t+3.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_BLANK;
      own_d1      <= 1'b0;
      Pix_Data    <= '0;
      hs_d        <= 3'b111;
      vs_d        <= 3'b111;
      Frame_Start <= 1'b0;
    end else begin
      state       <= state_nxt;
      own_d1      <= (state == S_DISP);
      Pix_Data    <= own_d1 ? Mem_RData : '0;
      hs_d        <= {hs_d[1:0], H_Sync_In};
      vs_d        <= {vs_d[1:0], V_Sync_In};
      Frame_Start <= (CountCol == 10'd0) && (CountRow == 10'd0);
    end
  end

  // RAM port: display read wins outright; an out-of-range write is consumed but dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Mem_Addr  <= '0;
      Mem_We    <= 1'b0;
      Mem_WData <= '0;
      Wr_Err    <= 1'b0;
    end else begin
      Mem_We <= 1'b0;
      Wr_Err <= 1'b0;
      if (active) begin
        Mem_Addr <= disp_addr;
      end else if (wr_fire) begin
        if (wr_in_range) begin
          Mem_Addr  <= Wr_Addr;
          Mem_WData <= Wr_Data;
          Mem_We    <= 1'b1;
        end else begin
          Wr_Err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: drives sync-generator counters and a pixel writer,
// models the RAM, and checks outputs against a cycle-level reference model.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int DW    = 3;
  localparam int AW    = 19;
  localparam int FB    = H_ACT * V_ACT;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  always #20 CLK = ~CLK;

  logic [9:0]    CountCol = '0;
  logic [9:0]    CountRow = '0;
  logic          H_Sync_In = 1'b1;
  logic          V_Sync_In = 1'b1;
  logic          Wr_Valid = 1'b0;
  logic [AW-1:0] Wr_Addr = '0;
  logic [DW-1:0] Wr_Data = '0;
  logic          Wr_Ready;
  logic          Wr_Err;
  logic [AW-1:0] Mem_Addr;
  logic          Mem_We;
  logic [DW-1:0] Mem_WData;
  logic [DW-1:0] Mem_RData = '0;
  logic [DW-1:0] Pix_Data;
  logic          H_Sync_Out;
  logic          V_Sync_Out;
  logic          Frame_Start;
  logic          Dbg_State;

  vga_fb_arbiter dut (
    .CLK(CLK), .RST_N(RST_N), .CountCol(CountCol), .CountRow(CountRow),
    .H_Sync_In(H_Sync_In), .V_Sync_In(V_Sync_In), .Wr_Valid(Wr_Valid),
    .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Wr_Ready(Wr_Ready), .Wr_Err(Wr_Err),
    .Mem_Addr(Mem_Addr), .Mem_We(Mem_We), .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData), .Pix_Data(Pix_Data), .H_Sync_Out(H_Sync_Out),
    .V_Sync_Out(V_Sync_Out), .Frame_Start(Frame_Start), .Dbg_State(Dbg_State)
  );

  // ---------------- single-port synchronous RAM ----------------
  logic [DW-1:0] ram [0:FB-1];
  logic fill_req  = 1'b0;
  logic fill_all7 = 1'b0;
  always @(posedge CLK) begin
    if (fill_req) begin
      for (int i = 0; i < FB; i++) ram[i] <= fill_all7 ? DW'(7) : DW'(i);
    end else if (Mem_We && int'(Mem_Addr) < FB) begin
      ram[Mem_Addr] <= Mem_WData;
    end
    if (int'(Mem_Addr) < FB) Mem_RData <= ram[Mem_Addr];
    else Mem_RData <= '0;
  end

  // ---------------- reference model state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int col_s = 0;
  int row_s = 0;
  logic          wv = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic          rand_sync = 1'b0;
  logic          cur_hs, cur_vs;
  logic          obs_ready, exp_ready, accepted;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          exp_we = 1'b0, exp_err = 1'b0, exp_fs = 1'b0;
  logic [DW-1:0] exp_pix;
  logic          exp_hs, exp_vs;
  logic [DW-1:0] exp_mem [0:FB-1];
  logic [DW+1:0] exp_q[$];

  // One pixel clock: present inputs, sample Wr_Ready mid-cycle, predict what the
  // port registers hold after the edge, and queue {hs,vs,pix} for the 3-cycle view.
  task automatic drive_cycle();
    logic act;
    logic [DW-1:0] pix;
    act = (col_s < H_ACT) && (row_s < V_ACT);
    if (rand_sync) begin
      cur_hs = 1'($urandom_range(0, 1));
      cur_vs = 1'($urandom_range(0, 1));
    end else begin
      cur_hs = !(col_s >= 656 && col_s < 752);
      cur_vs = !(row_s == 490 || row_s == 491);
    end
    CountCol = 10'(col_s);
    CountRow = 10'(row_s);
    H_Sync_In = cur_hs;
    V_Sync_In = cur_vs;
    Wr_Valid = wv;
    Wr_Addr = wa;
    Wr_Data = wd;
    @(negedge CLK);
    obs_ready = Wr_Ready;
    exp_ready = !act;
    accepted  = !act && wv;
    exp_fs  = (col_s == 0) && (row_s == 0);
    exp_we  = 1'b0;
    exp_err = 1'b0;
    pix = '0;
    if (act) begin
      exp_addr = AW'(row_s * H_ACT + col_s);
      pix = exp_mem[row_s * H_ACT + col_s];
    end else if (accepted) begin
      if (int'(wa) < FB) begin
        exp_we = 1'b1;
        exp_addr = wa;
        exp_wdata = wd;
        exp_mem[wa] = wd;
      end else begin
        exp_err = 1'b1;
      end
    end
    exp_q.push_back({cur_hs, cur_vs, pix});
    {exp_hs, exp_vs, exp_pix} = exp_q.pop_front();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    RST_N = 1'b0;
    CountCol = 10'd700; CountRow = 10'd10;
    H_Sync_In = 1'b0; V_Sync_In = 1'b0;
    Wr_Valid = 1'b1; Wr_Addr = AW'(42); Wr_Data = DW'(5);
    fill_all7 = 1'b0;
    fill_req = 1'b1;
    for (int i = 0; i < FB; i++) exp_mem[i] = DW'(i);
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      fill_req = 1'b0;
      n_cmp++; if (Mem_We !== 1'b0) begin n_err++; $display("FAIL reset_we got %0b exp 0", Mem_We); end
      n_cmp++; if (Wr_Ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b exp 0", Wr_Ready); end
      n_cmp++; if (Pix_Data !== 3'd0) begin n_err++; $display("FAIL reset_pix got %0d exp 0", Pix_Data); end
      n_cmp++; if (Mem_Addr !== '0) begin n_err++; $display("FAIL reset_addr got %0d exp 0", Mem_Addr); end
      n_cmp++; if ({Wr_Err, Frame_Start} !== 2'b00) begin n_err++; $display("FAIL reset_err_fs got %b exp 00", {Wr_Err, Frame_Start}); end
      n_cmp++; if ({H_Sync_Out, V_Sync_Out} !== 2'b11) begin n_err++; $display("FAIL reset_sync got %b exp 11", {H_Sync_Out, V_Sync_Out}); end
    end
    exp_addr = '0; exp_wdata = '0;
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b1, DW'(0)});
    exp_q.push_back({1'b1, 1'b1, DW'(0)});
    RST_N = 1'b1;
    wv = 1'b0; col_s = 0; row_s = 0;
    drive_cycle();
    n_cmp++; if (Frame_Start !== 1'b1) begin n_err++; $display("FAIL rel_fs1 got %0b exp 1", Frame_Start); end
    n_cmp++; if (Mem_Addr !== AW'(0)) begin n_err++; $display("FAIL rel_addr0 got %0d exp 0", Mem_Addr); end
    n_cmp++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL rel_ready got %0b exp 0", obs_ready); end
    col_s = 1;
    drive_cycle();
    n_cmp++; if (Frame_Start !== 1'b0) begin n_err++; $display("FAIL rel_fs2 got %0b exp 0", Frame_Start); end
    n_cmp++; if (Mem_Addr !== AW'(1)) begin n_err++; $display("FAIL rel_addr1 got %0d exp 1", Mem_Addr); end
  endtask

  task automatic test_active_read();
    logic hs0, vs0;
    rand_sync = 1'b1;
    wv = 1'b0;
    hs0 = 1'b1; vs0 = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k == 0) begin
        col_s = 5; row_s = 2;
      end else begin
        col_s = $urandom_range(0, H_ACT - 1);
        row_s = $urandom_range(0, V_ACT - 1);
      end
      drive_cycle();
      if (k == 0) begin
        hs0 = cur_hs; vs0 = cur_vs;
        n_cmp++; if (Mem_Addr !== AW'(1285)) begin n_err++; $display("FAIL rd_addr_5_2 got %0d exp 1285", Mem_Addr); end
      end
      if (k == 2) begin
        n_cmp++; if (Pix_Data !== 3'd5) begin n_err++; $display("FAIL rd_pix_5_2 got %0d exp 5", Pix_Data); end
        n_cmp++; if ({H_Sync_Out, V_Sync_Out} !== {hs0, vs0}) begin n_err++; $display("FAIL rd_sync_5_2 got %b exp %b", {H_Sync_Out, V_Sync_Out}, {hs0, vs0}); end
      end
      n_cmp++; if (Mem_Addr !== exp_addr) begin n_err++; $display("FAIL rd_addr got %0d exp %0d", Mem_Addr, exp_addr); end
      n_cmp++; if (Mem_We !== 1'b0) begin n_err++; $display("FAIL rd_we got %0b exp 0", Mem_We); end
      n_cmp++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rd_ready got %0b exp %0b", obs_ready, exp_ready); end
      n_cmp++; if (Pix_Data !== exp_pix) begin n_err++; $display("FAIL rd_pix got %0d exp %0d", Pix_Data, exp_pix); end
      n_cmp++; if ({H_Sync_Out, V_Sync_Out} !== {exp_hs, exp_vs}) begin n_err++; $display("FAIL rd_sync got %b exp %b", {H_Sync_Out, V_Sync_Out}, {exp_hs, exp_vs}); end
    end
    rand_sync = 1'b0;
  endtask

  task automatic test_write_stall();
    row_s = 0;
    wv = 1'b1; wa = AW'(100); wd = DW'(3);
    for (int c = 630; c <= 650; c++) begin
      col_s = c;
      drive_cycle();
      n_cmp++; if (obs_ready !== (c >= H_ACT)) begin n_err++; $display("FAIL st_ready col %0d got %0b exp %0b", c, obs_ready, c >= H_ACT); end
      n_cmp++; if (Mem_We !== exp_we) begin n_err++; $display("FAIL st_we col %0d got %0b exp %0b", c, Mem_We, exp_we); end
      n_cmp++; if (Mem_Addr !== exp_addr) begin n_err++; $display("FAIL st_addr col %0d got %0d exp %0d", c, Mem_Addr, exp_addr); end
      n_cmp++; if (Pix_Data !== exp_pix) begin n_err++; $display("FAIL st_pix col %0d got %0d exp %0d", c, Pix_Data, exp_pix); end
      if (c == H_ACT) begin
        n_cmp++; if ({Mem_We, Mem_Addr, Mem_WData} !== {1'b1, AW'(100), DW'(3)}) begin n_err++; $display("FAIL st_first_write got we=%0b addr=%0d data=%0d exp we=1 addr=100 data=3", Mem_We, Mem_Addr, Mem_WData); end
      end
    end
    wv = 1'b0;
  endtask

  task automatic test_back_to_back();
    int we_cnt, run, max_run;
    we_cnt = 0; run = 0; max_run = 0;
    wv = 1'b1;
    wa = AW'($urandom_range(0, FB - 1)); wd = DW'($urandom_range(0, 7));
    for (int k = 0; k < 180; k++) begin
      if (k < 170) begin row_s = 10; col_s = 630 + k; end
      else begin row_s = 11; col_s = k - 170; end
      drive_cycle();
      if (accepted) begin
        wa = AW'($urandom_range(0, FB - 1));
        wd = DW'($urandom_range(0, 7));
      end
      if (Mem_We === 1'b1) begin we_cnt++; run++; end else run = 0;
      if (run > max_run) max_run = run;
      n_cmp++; if ({Mem_We, Mem_Addr} !== {exp_we, exp_addr}) begin n_err++; $display("FAIL b2b_port k %0d got we=%0b addr=%0d exp we=%0b addr=%0d", k, Mem_We, Mem_Addr, exp_we, exp_addr); end
      if (exp_we) begin
        n_cmp++; if (Mem_WData !== exp_wdata) begin n_err++; $display("FAIL b2b_wdata k %0d got %0d exp %0d", k, Mem_WData, exp_wdata); end
      end
      n_cmp++; if (Pix_Data !== exp_pix) begin n_err++; $display("FAIL b2b_pix k %0d got %0d exp %0d", k, Pix_Data, exp_pix); end
      if (col_s == 799) begin
        n_cmp++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_799 got %0b exp 1", obs_ready); end
      end
      if (row_s == 11 && col_s == 0) begin
        n_cmp++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_wrap got %0b exp 0", obs_ready); end
      end
    end
    wv = 1'b0;
    n_cmp++; if (we_cnt !== 160) begin n_err++; $display("FAIL b2b_count got %0d exp 160", we_cnt); end
    n_cmp++; if (max_run !== 160) begin n_err++; $display("FAIL b2b_run got %0d exp 160", max_run); end
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] held;
    row_s = 500; col_s = 10;
    wv = 1'b0;
    drive_cycle();
    held = exp_addr;
    col_s = 11; wv = 1'b1; wa = AW'(FB); wd = DW'(5);
    drive_cycle();
    n_cmp++; if (Wr_Err !== 1'b1) begin n_err++; $display("FAIL oor_err got %0b exp 1", Wr_Err); end
    n_cmp++; if (Mem_We !== 1'b0) begin n_err++; $display("FAIL oor_we got %0b exp 0", Mem_We); end
    n_cmp++; if (Mem_Addr !== held) begin n_err++; $display("FAIL oor_hold got %0d exp %0d", Mem_Addr, held); end
    col_s = 12; wa = AW'(1234); wd = DW'(6);
    drive_cycle();
    n_cmp++; if (Wr_Err !== 1'b0) begin n_err++; $display("FAIL oor_err_clr got %0b exp 0", Wr_Err); end
    n_cmp++; if ({Mem_We, Mem_Addr, Mem_WData} !== {1'b1, AW'(1234), DW'(6)}) begin n_err++; $display("FAIL oor_next got we=%0b addr=%0d data=%0d exp we=1 addr=1234 data=6", Mem_We, Mem_Addr, Mem_WData); end
    for (int k = 0; k < 40; k++) begin
      col_s = 13 + k;
      wv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) wa = AW'($urandom_range(0, (1 << AW) - 1));
      else wa = AW'($urandom_range(FB - 4, FB + 4));
      wd = DW'($urandom_range(0, 7));
      drive_cycle();
      n_cmp++; if ({Wr_Err, Mem_We} !== {exp_err, exp_we}) begin n_err++; $display("FAIL oor_rand_flags k %0d got err=%0b we=%0b exp err=%0b we=%0b", k, Wr_Err, Mem_We, exp_err, exp_we); end
      n_cmp++; if ({Mem_Addr, Mem_WData} !== {exp_addr, exp_wdata}) begin n_err++; $display("FAIL oor_rand_port k %0d got addr=%0d data=%0d exp addr=%0d data=%0d", k, Mem_Addr, Mem_WData, exp_addr, exp_wdata); end
    end
    wv = 1'b0;
  endtask

  task automatic test_full_frame();
    int rows [12] = '{0, 1, 2, 3, 478, 479, 480, 481, 490, 491, 523, 524};
    int pix7_cnt, fs_cnt;
    pix7_cnt = 0; fs_cnt = 0;
    wv = 1'b0;
    row_s = 500;
    for (int k = 0; k < 4; k++) begin col_s = 700 + k; drive_cycle(); end
    fill_all7 = 1'b1;
    fill_req = 1'b1;
    for (int i = 0; i < FB; i++) exp_mem[i] = DW'(7);
    col_s = 704;
    drive_cycle();
    fill_req = 1'b0;
    wa = AW'($urandom_range(0, FB - 1)); wd = DW'(7);
    for (int r = 0; r < 13; r++) begin
      for (int c = 0; c < 800; c++) begin
        if (r == 12 && c > 0) break;
        row_s = (r == 12) ? 0 : rows[r];
        col_s = c;
        if (!wv) wv = ($urandom_range(0, 3) == 0);
        drive_cycle();
        if (accepted) begin
          wv = 1'b0;
          wa = AW'($urandom_range(0, FB - 1));
        end
        if (Pix_Data === 3'd7) pix7_cnt++;
        if (Frame_Start === 1'b1) fs_cnt++;
        n_cmp++; if (Pix_Data !== exp_pix) begin n_err++; $display("FAIL ff_pix row %0d col %0d got %0d exp %0d", row_s, c, Pix_Data, exp_pix); end
        n_cmp++; if ({H_Sync_Out, V_Sync_Out} !== {exp_hs, exp_vs}) begin n_err++; $display("FAIL ff_sync row %0d col %0d got %b exp %b", row_s, c, {H_Sync_Out, V_Sync_Out}, {exp_hs, exp_vs}); end
        n_cmp++; if (Frame_Start !== exp_fs) begin n_err++; $display("FAIL ff_fs row %0d col %0d got %0b exp %0b", row_s, c, Frame_Start, exp_fs); end
        n_cmp++; if ({Mem_We, Mem_Addr} !== {exp_we, exp_addr}) begin n_err++; $display("FAIL ff_port row %0d col %0d got we=%0b addr=%0d exp we=%0b addr=%0d", row_s, c, Mem_We, Mem_Addr, exp_we, exp_addr); end
        n_cmp++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL ff_ready row %0d col %0d got %0b exp %0b", row_s, c, obs_ready, exp_ready); end
      end
    end
    wv = 1'b0;
    row_s = 500;
    for (int k = 0; k < 2; k++) begin
      col_s = k;
      drive_cycle();
      if (Pix_Data === 3'd7) pix7_cnt++;
      n_cmp++; if (Pix_Data !== exp_pix) begin n_err++; $display("FAIL ff_tail_pix k %0d got %0d exp %0d", k, Pix_Data, exp_pix); end
    end
    // Six active rows visited plus the wrapped (0,0) pixel.
    n_cmp++; if (pix7_cnt !== 6 * H_ACT + 1) begin n_err++; $display("FAIL ff_pix7_count got %0d exp %0d", pix7_cnt, 6 * H_ACT + 1); end
    n_cmp++; if (fs_cnt !== 2) begin n_err++; $display("FAIL ff_fs_count got %0d exp 2", fs_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_active_read();
    test_write_stall();
    test_back_to_back();
    test_out_of_range();
    test_full_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
